k16_program_loader: RTL

//   Boot loader sitting upstream of the K16 processor's program memory. Receives a framed byte

---
 rtl/k16_loader_pkg.sv | 18 +
 rtl/k16_loader_timer.sv | 29 ++
 rtl/k16_program_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/k16_loader_pkg.sv
// Shared types and constants for the K16 boot loader: frame FSM states and error codes.
package k16_loader_pkg;

  typedef enum logic [2:0] {
    LEN_H = 3'd0,
    LEN_L = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_LEN     = 2'd3;

endpackage

// File: rtl/k16_loader_timer.sv
// Inter-byte idle counter; expired holds once the count reaches TIMEOUT-1 until cleared.
module k16_loader_timer #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  assign expired = (count == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/k16_program_loader.sv
// Framed byte-stream loader for K16 program RAM; holds the CPU in reset until a frame
// with a matching checksum has been written.
module k16_program_loader
  import k16_loader_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        load_req,
  output logic        pm_we,
  output logic [15:0] pm_addr,
  output logic [23:0] pm_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] words_loaded,
  output state_t      dbg_state
);

  // Handshake: a byte moves on any posedge where rx_valid && rx_ready; rx_ready depends
  // only on state, so there is no backpressure while a frame is in progress.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state;
  logic [15:0] len;
  logic [1:0]  idx;
  logic [7:0]  b0;
  logic [7:0]  b1;
  logic [7:0]  csum;
  logic        xfer;
  logic        counting;
  logic        expired;
  logic [15:0] n_full;

  assign rx_ready  = (state == LEN_H) || (state == LEN_L) || (state == DATA) || (state == CSUM);
  assign counting  = (state == LEN_L) || (state == DATA) || (state == CSUM);
  assign xfer      = rx_valid && rx_ready;
  assign n_full    = {len[15:8], rx_data};
  assign dbg_state = state;

  k16_loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (load_req || xfer || !counting),
    .enable  (counting),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LEN_H;
      len          <= '0;
      idx          <= '0;
      b0           <= '0;
      b1           <= '0;
      csum         <= '0;
      pm_we        <= 1'b0;
      pm_addr      <= '0;
      pm_wdata     <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
    end else begin
      pm_we <= 1'b0;
      if (load_req) begin
        // Restart wins over any byte presented in the same cycle.
        state        <= LEN_H;
        idx          <= '0;
        csum         <= '0;
        cpu_rst      <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
        err_code     <= ERR_NONE;
        words_loaded <= '0;
      end else begin
        case (state)
          LEN_H: begin
            if (xfer) begin
              len[15:8] <= rx_data;
              state     <= LEN_L;
            end
          end
          LEN_L: begin
            if (xfer) begin
              len[7:0] <= rx_data;
              if ({1'b0, n_full} > DEPTH_W) begin
                state    <= ERR;
                error    <= 1'b1;
                err_code <= ERR_LEN;
              end else if (n_full == 16'd0) begin
                state <= CSUM;
              end else begin
                state <= DATA;
              end
            end else if (expired) begin
              state    <= ERR;
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end
          end
          DATA: begin
            if (xfer) begin
              csum <= csum + rx_data;
              case (idx)
                2'd0: begin
                  b0  <= rx_data;
                  idx <= 2'd1;
                end
                2'd1: begin
                  b1  <= rx_data;
                  idx <= 2'd2;
                end
                default: begin
                  idx          <= 2'd0;
                  pm_we        <= 1'b1;
                  pm_addr      <= words_loaded;
                  pm_wdata     <= {b0, b1, rx_data};
                  words_loaded <= words_loaded + 16'd1;
                  if (words_loaded == len - 16'd1) begin
                    state <= CSUM;
                  end
                end
              endcase
            end else if (expired) begin
              state    <= ERR;
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end
          end
          CSUM: begin
            if (xfer) begin
              if (rx_data == csum) begin
                state   <= RUN;
                cpu_rst <= 1'b0;
                done    <= 1'b1;
              end else begin
                state    <= ERR;
                error    <= 1'b1;
                err_code <= ERR_CSUM;
              end
            end else if (expired) begin
              state    <= ERR;
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end
          end
          default: begin
            // RUN and ERR hold until load_req or rst.
          end
        endcase
      end
    end
  end

endmodule
